// File: rtl/sys_pkg.sv
// Shared definitions for the response path: packer state encoding and byte-lane count.
package sys_pkg;

    localparam logic [1:0] PK_IDLE    = 2'b00;
    localparam logic [1:0] PK_SEND_B0 = 2'b01;
    localparam logic [1:0] PK_SEND_B1 = 2'b10;

    localparam int BYTES_PER_ALU = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = PK_IDLE,
        ST_SEND_B0 = PK_SEND_B0,
        ST_SEND_B1 = PK_SEND_B1
    } pk_state_e;

endpackage

// File: rtl/resp_byte_packer.sv
// Serializes a register-file byte or a two-byte ALU result into the TX FIFO,
// LSB first, one write per byte, holding while the FIFO reports full.
module resp_byte_packer
    import sys_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RD_DATA,
    input  logic                     RD_DATA_VALID,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VALID,
    input  logic                     FIFO_FULL,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_DATA_VALID,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    if (ALU_OUT_WIDTH != BYTES_PER_ALU * DATA_WIDTH) begin : g_width_check
        $error("ALU_OUT_WIDTH must be exactly two bytes wide");
    end

    pk_state_e                state_reg;
    pk_state_e                state_next;
    logic [ALU_OUT_WIDTH-1:0] buf_reg;
    logic [ALU_OUT_WIDTH-1:0] buf_next;
    logic                     two_byte_reg;
    logic                     two_byte_next;
    logic [DATA_WIDTH-1:0]    tx_byte_reg;
    logic [DATA_WIDTH-1:0]    tx_byte_next;
    logic                     overrun_reg;
    logic                     overrun_next;
    logic                     write;
    logic                     any_strobe;
    logic                     sel_hi_next;

    // Byte lanes of the buffer contents that will be live after this edge.
    logic [DATA_WIDTH-1:0] next_lane [BYTES_PER_ALU];

    for (genvar gi = 0; gi < BYTES_PER_ALU; gi++) begin : g_lane
        assign next_lane[gi] = buf_next[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign any_strobe = ALU_OUT_VALID | RD_DATA_VALID;
    assign write      = (state_reg != ST_IDLE) & ~FIFO_FULL & ~RST;

    // Next-state logic: advance only on a completed FIFO write.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_strobe) begin
                    state_next = ST_SEND_B0;
                end
            end
            ST_SEND_B0: begin
                if (write) begin
                    state_next = two_byte_reg ? ST_SEND_B1 : ST_IDLE;
                end
            end
            ST_SEND_B1: begin
                if (write) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture and overrun tracking. When both strobes arrive together the ALU
    // result is kept and the register byte is the one lost.
    always_comb begin
        buf_next      = buf_reg;
        two_byte_next = two_byte_reg;
        overrun_next  = overrun_reg;
        if (state_reg == ST_IDLE) begin
            if (ALU_OUT_VALID) begin
                buf_next      = ALU_OUT;
                two_byte_next = 1'b1;
                if (RD_DATA_VALID) begin
                    overrun_next = 1'b1;
                end
            end else if (RD_DATA_VALID) begin
                buf_next[DATA_WIDTH-1:0] = RD_DATA;
                two_byte_next            = 1'b0;
            end
        end else if (any_strobe) begin
            overrun_next = 1'b1;
        end
    end

    // The output byte is registered from the lane the next state will present;
    // in IDLE the last byte sent stays on the bus.
    assign sel_hi_next = (state_next == ST_SEND_B1);

    always_comb begin
        tx_byte_next = tx_byte_reg;
        if (state_next != ST_IDLE) begin
            tx_byte_next = next_lane[sel_hi_next];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_reg      <= '0;
            two_byte_reg <= 1'b0;
            tx_byte_reg  <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            buf_reg      <= buf_next;
            two_byte_reg <= two_byte_next;
            tx_byte_reg  <= tx_byte_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign TX_P_DATA     = tx_byte_reg;
    assign TX_DATA_VALID = write;
    assign BUSY          = (state_reg != ST_IDLE) & ~RST;
    assign OVERRUN       = overrun_reg;

endmodule

// File: tb/tb_resp_byte_packer.sv
// Directed bench for resp_byte_packer: single byte, ALU pair, stall, collision,
// overrun while busy and reset mid-transfer.
module tb_resp_byte_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rd_data = '0;
    logic        rd_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_valid = 1'b0;
    logic        fifo_full = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_q [8];
    int         wr_cyc [8];
    int         nwr;

    always #5 clk = ~clk;

    resp_byte_packer dut (
        .CLK           (clk),
        .RST           (rst),
        .RD_DATA       (rd_data),
        .RD_DATA_VALID (rd_valid),
        .ALU_OUT       (alu_out),
        .ALU_OUT_VALID (alu_valid),
        .FIFO_FULL     (fifo_full),
        .TX_P_DATA     (tx_data),
        .TX_DATA_VALID (tx_valid),
        .BUSY          (busy),
        .OVERRUN       (overrun)
    );

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled one more time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_valid = 1'b0;
        alu_valid = 1'b0;
        fifo_full = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        cyc();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        rst = 1'b0;
        cyc();
        #1;
        checks++;
        if (tx_data !== 8'h00 || overrun !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state data=%h ovr=%b busy=%b valid=%b expected 00 0 0 0",
                     tx_data, overrun, busy, tx_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_rd_byte();
        do_reset();
        rd_data = 8'hA5;
        rd_valid = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_cycle_n busy=%b valid=%b expected 0 0", busy, tx_valid);
        end
        cyc();
        rd_valid = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_write valid=%b data=%h busy=%b expected 1 a5 1", tx_valid, tx_data, busy);
        end
        cyc();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rd_done valid=%b busy=%b ovr=%b expected 0 0 0", tx_valid, busy, overrun);
        end
        $display("test_rd_byte done");
    endtask

    task automatic test_alu();
        do_reset();
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        cyc();
        alu_valid = 1'b0;
        nwr = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (tx_valid === 1'b1 && nwr < 8) begin
                wr_q[nwr] = tx_data;
                wr_cyc[nwr] = i;
                nwr++;
            end
            cyc();
        end
        checks++;
        if (nwr !== 2) begin
            errors++;
            $display("FAIL alu_count writes=%0d expected 2", nwr);
        end else begin
            checks++;
            if (wr_q[0] !== 8'h34 || wr_q[1] !== 8'h12 || wr_cyc[0] !== 0 || wr_cyc[1] !== 1) begin
                errors++;
                $display("FAIL alu_bytes got %h@%0d %h@%0d expected 34@0 12@1",
                         wr_q[0], wr_cyc[0], wr_q[1], wr_cyc[1]);
            end
        end
        $display("test_alu done");
    endtask

    task automatic test_stall();
        do_reset();
        alu_out = 16'hBEEF;
        alu_valid = 1'b1;
        cyc();
        alu_valid = 1'b0;
        fifo_full = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            checks++;
            if (tx_valid !== 1'b0 || tx_data !== 8'hEF || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle N+%0d valid=%b data=%h busy=%b expected 0 ef 1",
                         i, tx_valid, tx_data, busy);
            end
            cyc();
        end
        fifo_full = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
            errors++;
            $display("FAIL stall_b0 valid=%b data=%h expected 1 ef", tx_valid, tx_data);
        end
        cyc();
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
            errors++;
            $display("FAIL stall_b1 valid=%b data=%h expected 1 be", tx_valid, tx_data);
        end
        cyc();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        $display("test_stall done");
    endtask

    task automatic test_collision();
        int n77;
        do_reset();
        alu_out = 16'h0102;
        rd_data = 8'h77;
        alu_valid = 1'b1;
        rd_valid = 1'b1;
        cyc();
        alu_valid = 1'b0;
        rd_valid = 1'b0;
        nwr = 0;
        n77 = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (tx_valid === 1'b1 && nwr < 8) begin
                wr_q[nwr] = tx_data;
                if (tx_data === 8'h77) n77++;
                nwr++;
            end
            cyc();
        end
        checks++;
        if (nwr !== 2 || wr_q[0] !== 8'h02 || wr_q[1] !== 8'h01) begin
            errors++;
            $display("FAIL collision_bytes writes=%0d first=%h second=%h expected 2 02 01",
                     nwr, wr_q[0], wr_q[1]);
        end
        checks++;
        if (n77 !== 0) begin
            errors++;
            $display("FAIL collision_rd_dropped rd byte writes=%0d expected 0", n77);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL collision_overrun ovr=%b expected 1", overrun);
        end
        $display("test_collision done");
    endtask

    task automatic test_overrun_busy();
        do_reset();
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        cyc();
        alu_valid = 1'b0;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            // Second strobe lands in the SEND_B1 (final write) cycle.
            if (i == 1) begin
                alu_out = 16'h5678;
                alu_valid = 1'b1;
            end else begin
                alu_valid = 1'b0;
            end
            #1;
            if (tx_valid === 1'b1 && nwr < 8) begin
                wr_q[nwr] = tx_data;
                nwr++;
            end
            cyc();
        end
        alu_valid = 1'b0;
        checks++;
        if (nwr !== 2 || wr_q[0] !== 8'h34 || wr_q[1] !== 8'h12) begin
            errors++;
            $display("FAIL overrun_bytes writes=%0d first=%h second=%h expected 2 34 12",
                     nwr, wr_q[0], wr_q[1]);
        end
        for (int i = 0; i < 3; i++) cyc();
        #1;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky ovr=%b busy=%b expected 1 0", overrun, busy);
        end
        do_reset();
        #1;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear ovr=%b expected 0", overrun);
        end
        $display("test_overrun_busy done");
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        cyc();
        alu_out = 16'h5678;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
            errors++;
            $display("FAIL midrst_b0 valid=%b data=%h expected 1 34", tx_valid, tx_data);
        end
        cyc();
        alu_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL midrst_assert valid=%b busy=%b ovr=%b expected 0 0 1", tx_valid, busy, overrun);
        end
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after valid=%b busy=%b data=%h ovr=%b expected 0 0 00 0",
                     tx_valid, busy, tx_data, overrun);
        end
        rd_data = 8'hA5;
        rd_valid = 1'b1;
        cyc();
        rd_valid = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_rd valid=%b data=%h busy=%b expected 1 a5 1", tx_valid, tx_data, busy);
        end
        cyc();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_rd_done valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
        $display("test_reset_mid_op done");
    endtask

    initial begin
        test_reset();
        test_rd_byte();
        test_alu();
        test_stall();
        test_collision();
        test_overrun_busy();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
